// File: rtl/kernel_gemm_avmm.sv
// GEMM kernel over an Avalon-MM master: D := alpha*A*B (+ beta*D), one element
// fetched per read and each result written back in place, row-major.
module kernel_gemm_avmm #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic            stall,
  input  logic [DW-1:0]   alpha,
  input  logic [DW-1:0]   beta,
  input  logic            mode,
  input  logic [AW-1:0]   A,
  input  logic [AW-1:0]   B,
  input  logic [AW-1:0]   D,
  output logic [AW-1:0]   avm_address,
  output logic [DW/8-1:0] avm_byteenable,
  output logic            avm_read,
  output logic            avm_write,
  output logic [DW-1:0]   avm_writedata,
  input  logic [DW-1:0]   avm_readdata,
  input  logic            avm_readdatavalid,
  input  logic            avm_waitrequest
);

  localparam int unsigned BYTES = DW / 8;
  localparam int unsigned IW    = $clog2(N);

  typedef enum logic [3:0] {
    IDLE, RD_A, WT_A, RD_B, WT_B, RD_D, WT_D, COMP, WR, DONE
  } state_t;

  state_t        r_state, w_nxt_state;
  logic [IW-1:0] r_i, r_j, r_k, w_nxt_i, w_nxt_j, w_nxt_k;
  logic [DW-1:0] r_acc, r_a_val, r_d_old, r_result;
  logic [DW-1:0] w_nxt_acc, w_nxt_a_val, w_nxt_d_old, w_nxt_result;
  logic [DW-1:0] r_alpha, r_beta, w_nxt_alpha, w_nxt_beta;
  logic          r_mode, w_nxt_mode;
  logic [AW-1:0] r_a_base, r_b_base, r_d_base;
  logic [AW-1:0] w_nxt_a_base, w_nxt_b_base, w_nxt_d_base;
  logic          r_busy, r_done, r_read, r_write;
  logic          w_nxt_busy, w_nxt_done, w_nxt_read, w_nxt_write;
  logic [AW-1:0] r_addr, w_nxt_addr;
  logic [DW-1:0] r_wdata, w_nxt_wdata;

  // Byte address of element [r][c] of a row-major N x N matrix at base.
  function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] base,
                                               input logic [IW-1:0] r,
                                               input logic [IW-1:0] c);
    return base + ((AW'(r) * AW'(N)) + AW'(c)) * AW'(BYTES);
  endfunction

  assign busy           = r_busy;
  assign done           = r_done;
  assign avm_read       = r_read;
  assign avm_write      = r_write;
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = '1;

  // Next-state, datapath and next-output logic; arithmetic wraps modulo 2^DW.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_i      = r_i;
    w_nxt_j      = r_j;
    w_nxt_k      = r_k;
    w_nxt_acc    = r_acc;
    w_nxt_a_val  = r_a_val;
    w_nxt_d_old  = r_d_old;
    w_nxt_result = r_result;
    w_nxt_alpha  = r_alpha;
    w_nxt_beta   = r_beta;
    w_nxt_mode   = r_mode;
    w_nxt_a_base = r_a_base;
    w_nxt_b_base = r_b_base;
    w_nxt_d_base = r_d_base;
    w_nxt_addr   = '0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt_alpha  = alpha;
          w_nxt_beta   = beta;
          w_nxt_mode   = mode;
          w_nxt_a_base = A;
          w_nxt_b_base = B;
          w_nxt_d_base = D;
          w_nxt_i      = '0;
          w_nxt_j      = '0;
          w_nxt_k      = '0;
          w_nxt_acc    = '0;
          w_nxt_state  = RD_A;
        end
      end
      RD_A: if (!avm_waitrequest) w_nxt_state = WT_A;
      WT_A: begin
        if (avm_readdatavalid) begin
          w_nxt_a_val = avm_readdata;
          w_nxt_state = RD_B;
        end
      end
      RD_B: if (!avm_waitrequest) w_nxt_state = WT_B;
      WT_B: begin
        if (avm_readdatavalid) begin
          w_nxt_acc = r_acc + r_a_val * avm_readdata;
          if (r_k < IW'(N - 1)) begin
            w_nxt_k     = r_k + IW'(1);
            w_nxt_state = RD_A;
          end else begin
            w_nxt_state = r_mode ? COMP : RD_D;
          end
        end
      end
      RD_D: if (!avm_waitrequest) w_nxt_state = WT_D;
      WT_D: begin
        if (avm_readdatavalid) begin
          w_nxt_d_old = avm_readdata;
          w_nxt_state = COMP;
        end
      end
      COMP: begin
        w_nxt_result = r_alpha * r_acc + (r_mode ? '0 : r_beta * r_d_old);
        w_nxt_state  = WR;
      end
      WR: begin
        if (!avm_waitrequest) begin
          w_nxt_acc = '0;
          w_nxt_k   = '0;
          if (r_j == IW'(N - 1)) begin
            w_nxt_j = '0;
            if (r_i == IW'(N - 1)) begin
              w_nxt_i     = '0;
              w_nxt_state = DONE;
            end else begin
              w_nxt_i     = r_i + IW'(1);
              w_nxt_state = RD_A;
            end
          end else begin
            w_nxt_j     = r_j + IW'(1);
            w_nxt_state = RD_A;
          end
        end
      end
      DONE: if (!stall) w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase

    w_nxt_busy  = (w_nxt_state != IDLE);
    w_nxt_done  = (w_nxt_state == DONE);
    w_nxt_read  = (w_nxt_state == RD_A) || (w_nxt_state == RD_B) ||
                  (w_nxt_state == RD_D);
    w_nxt_write = (w_nxt_state == WR);

    // Address is a pure function of the next state and counters, so it stays
    // stable for as long as a request is held off by waitrequest.
    case (w_nxt_state)
      RD_A:    w_nxt_addr = elem_addr(w_nxt_a_base, w_nxt_i, w_nxt_k);
      RD_B:    w_nxt_addr = elem_addr(w_nxt_b_base, w_nxt_k, w_nxt_j);
      RD_D,
      WR:      w_nxt_addr = elem_addr(w_nxt_d_base, w_nxt_i, w_nxt_j);
      default: w_nxt_addr = '0;
    endcase
    w_nxt_wdata = w_nxt_write ? w_nxt_result : '0;
  end

  // State, datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_a_val  <= '0;
      r_d_old  <= '0;
      r_result <= '0;
      r_alpha  <= '0;
      r_beta   <= '0;
      r_mode   <= 1'b0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_d_base <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_i      <= w_nxt_i;
      r_j      <= w_nxt_j;
      r_k      <= w_nxt_k;
      r_acc    <= w_nxt_acc;
      r_a_val  <= w_nxt_a_val;
      r_d_old  <= w_nxt_d_old;
      r_result <= w_nxt_result;
      r_alpha  <= w_nxt_alpha;
      r_beta   <= w_nxt_beta;
      r_mode   <= w_nxt_mode;
      r_a_base <= w_nxt_a_base;
      r_b_base <= w_nxt_b_base;
      r_d_base <= w_nxt_d_base;
      r_busy   <= w_nxt_busy;
      r_done   <= w_nxt_done;
      r_read   <= w_nxt_read;
      r_write  <= w_nxt_write;
      r_addr   <= w_nxt_addr;
      r_wdata  <= w_nxt_wdata;
    end
  end

endmodule

// File: tb/tb_kernel_gemm_avmm.sv
// Bench for kernel_gemm_avmm (N=2, DW=32): Avalon memory model stepped once per
// cycle from the main thread, checked against a plain-arithmetic GEMM model.
module tb_kernel_gemm_avmm;

  localparam int AI = 64;   // word index of A at byte 0x100
  localparam int BI = 128;  // B at 0x200
  localparam int DI = 192;  // D at 0x300
  localparam logic [63:0] ABASE = 64'h100;
  localparam logic [63:0] BBASE = 64'h200;
  localparam logic [63:0] DBASE = 64'h300;

  logic        clock, reset, start, busy, done, stall, mode;
  logic [31:0] alpha, beta;
  logic [63:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read, avm_write, avm_readdatavalid, avm_waitrequest;
  logic [31:0] avm_writedata, avm_readdata;

  kernel_gemm_avmm #(.N(2), .DW(32), .AW(64)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .stall(stall), .alpha(alpha), .beta(beta), .mode(mode),
    .A(ABASE), .B(BBASE), .D(DBASE),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          vectors, miscompares;
  logic [31:0] mem [0:1023];
  logic [31:0] ma [4], mb [4], md [4], expd [4];
  int          wait_n, held, d_reads, order_err, stab_err, both_err, wr_cnt [4];
  bit          d_rd_seen [4];
  logic        cur_mode, l_rd, l_wr, l_wait;
  logic [63:0] l_addr;
  logic [31:0] l_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory slave: completes the transfer accepted at the edge just passed, then
  // decides waitrequest for the request now on the bus.
  task automatic slave_step();
    int idx;
    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom;
    idx = int'((l_addr - DBASE) >> 2);
    if (l_rd && !l_wait) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem[l_addr[11:2]];
      if (l_addr >= DBASE && l_addr < DBASE + 64'd16) begin
        d_reads++;
        d_rd_seen[idx] = 1'b1;
      end
    end
    if (l_wr && !l_wait) begin
      mem[l_addr[11:2]] = l_wdata;
      if (l_addr >= DBASE && l_addr < DBASE + 64'd16) begin
        wr_cnt[idx]++;
        if (!cur_mode && !d_rd_seen[idx]) order_err++;
      end
    end
    if (l_wait && (l_rd || l_wr) &&
        (avm_read !== l_rd || avm_write !== l_wr ||
         avm_address !== l_addr || avm_writedata !== l_wdata))
      stab_err++;
    if (avm_read && avm_write) both_err++;
    if ((avm_read || avm_write) && held < wait_n) begin
      avm_waitrequest = 1'b1;
      held++;
    end else begin
      avm_waitrequest = 1'b0;
      held = 0;
    end
    l_rd = avm_read; l_wr = avm_write; l_wait = avm_waitrequest;
    l_addr = avm_address; l_wdata = avm_writedata;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    slave_step();
  endtask

  task automatic load_mem();
    for (int e = 0; e < 4; e++) begin
      mem[AI + e] = ma[e];
      mem[BI + e] = mb[e];
      mem[DI + e] = md[e];
    end
  endtask

  // Reference: D[i][j] = alpha*sum_k A[i][k]*B[k][j] (+ beta*D[i][j]), mod 2^32.
  task automatic model(input logic [31:0] al, input logic [31:0] be, input logic mo);
    logic [31:0] acc;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc = 32'd0;
        for (int k = 0; k < 2; k++) acc = acc + ma[i*2+k] * mb[k*2+j];
        expd[i*2+j] = al * acc + (mo ? 32'd0 : be * md[i*2+j]);
      end
  endtask

  task automatic run_call(input logic [31:0] al, input logic [31:0] be,
                          input logic mo, output int cyc);
    d_reads = 0; order_err = 0; stab_err = 0; both_err = 0;
    for (int e = 0; e < 4; e++) begin wr_cnt[e] = 0; d_rd_seen[e] = 1'b0; end
    cur_mode = mo; alpha = al; beta = be; mode = mo;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", 64'(busy), 64'd1);
    while (done !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
  endtask

  task automatic verify(input string tag, input logic mo, input int cyc, input bit chk_cyc);
    for (int e = 0; e < 4; e++) begin
      check($sformatf("%s_d%0d", tag, e), 64'(mem[DI + e]), 64'(expd[e]));
      check($sformatf("%s_wrcnt%0d", tag, e), 64'(wr_cnt[e]), 64'd1);
    end
    check({tag, "_order"}, 64'(order_err), 64'd0);
    check({tag, "_stable"}, 64'(stab_err), 64'd0);
    check({tag, "_rd_wr_overlap"}, 64'(both_err), 64'd0);
    check({tag, "_d_reads"}, 64'(d_reads), mo ? 64'd0 : 64'd4);
    if (chk_cyc) check({tag, "_done_cycle"}, 64'(cyc), 64'(1 + 4 * (10 + (mo ? 0 : 2))));
  endtask

  task automatic load_spec_case();
    ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
    mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
    for (int e = 0; e < 4; e++) md[e] = 32'd1;
    load_mem();
  endtask

  initial begin
    int cyc, nreads;
    vectors = 0; miscompares = 0;
    reset = 1'b1; start = 1'b0; stall = 1'b0; mode = 1'b0;
    alpha = '0; beta = '0;
    avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    wait_n = 0; held = 0; cur_mode = 1'b0;
    l_rd = 1'b0; l_wr = 1'b0; l_wait = 1'b0; l_addr = '0; l_wdata = '0;
    for (int e = 0; e < 1024; e++) mem[e] = '0;

    // Reset state
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_read", 64'(avm_read), 64'd0);
    check("rst_write", 64'(avm_write), 64'd0);
    check("rst_addr", avm_address, 64'd0);
    check("rst_wdata", 64'(avm_writedata), 64'd0);
    check("byteenable", 64'(avm_byteenable), 64'hF);
    reset = 1'b0;
    tick();

    // Worked example, mode 0
    load_spec_case();
    expd[0] = 41; expd[1] = 47; expd[2] = 89; expd[3] = 103;
    run_call(32'd2, 32'd3, 1'b0, cyc);
    verify("ex_mode0", 1'b0, cyc, 1'b1);
    tick();

    // Worked example, mode 1
    load_spec_case();
    expd[0] = 38; expd[1] = 44; expd[2] = 86; expd[3] = 100;
    run_call(32'd2, 32'd3, 1'b1, cyc);
    verify("ex_mode1", 1'b1, cyc, 1'b1);
    tick();

    // Three waitrequest cycles on every access
    wait_n = 3;
    load_spec_case();
    expd[0] = 41; expd[1] = 47; expd[2] = 89; expd[3] = 103;
    run_call(32'd2, 32'd3, 1'b0, cyc);
    verify("waitreq", 1'b0, cyc, 1'b0);
    tick();
    wait_n = 0;

    // Return stall held at DONE, with an ignored start pulse inside the window
    load_spec_case();
    stall = 1'b1;
    run_call(32'd2, 32'd3, 1'b0, cyc);
    verify("stall", 1'b0, cyc, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_done_c%0d", c), 64'(done), 64'd1);
      check($sformatf("stall_busy_c%0d", c), 64'(busy), 64'd1);
      start = (c == 2);
      if (c == 4) stall = 1'b0;
      tick();
    end
    start = 1'b0;
    check("stall_release_done", 64'(done), 64'd0);
    check("stall_release_busy", 64'(busy), 64'd0);
    tick(); tick(); tick();
    check("stall_start_ignored_busy", 64'(busy), 64'd0);
    check("stall_start_ignored_read", 64'(avm_read), 64'd0);

    // Reset during the third read, then a fresh call
    load_spec_case();
    alpha = 32'd2; beta = 32'd3; mode = 1'b0; cur_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    nreads = 0;
    for (int c = 0; c < 100; c++) begin
      if (avm_read) nreads++;
      if (nreads == 3) break;
      tick();
    end
    check("third_read_seen", 64'(nreads), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_read", 64'(avm_read), 64'd0);
    check("abort_write", 64'(avm_write), 64'd0);
    check("abort_addr", avm_address, 64'd0);
    check("abort_wdata", 64'(avm_writedata), 64'd0);
    tick(); tick(); tick();
    check("abort_idle_after_stale_valid", 64'(busy), 64'd0);
    load_spec_case();
    expd[0] = 41; expd[1] = 47; expd[2] = 89; expd[3] = 103;
    run_call(32'd2, 32'd3, 1'b0, cyc);
    verify("post_abort", 1'b0, cyc, 1'b1);
    tick();

    // Wrap: alpha = 0x80000000 times 2 is zero modulo 2^32
    ma[0] = 1; ma[1] = 0; ma[2] = 0; ma[3] = 1;
    mb[0] = 2; mb[1] = 0; mb[2] = 0; mb[3] = 2;
    for (int e = 0; e < 4; e++) md[e] = 32'hDEAD_BEEF;
    load_mem();
    model(32'h8000_0000, 32'd5, 1'b1);
    run_call(32'h8000_0000, 32'd5, 1'b1, cyc);
    verify("wrap", 1'b1, cyc, 1'b1);
    tick();

    // Randomized calls against the reference model
    for (int t = 0; t < 8; t++) begin
      logic [31:0] ra, rb;
      logic        rm;
      for (int e = 0; e < 4; e++) begin
        ma[e] = $urandom; mb[e] = $urandom; md[e] = $urandom;
      end
      load_mem();
      ra = $urandom; rb = $urandom; rm = 1'($urandom_range(0, 1));
      wait_n = $urandom_range(0, 2);
      model(ra, rb, rm);
      run_call(ra, rb, rm, cyc);
      verify($sformatf("rand%0d", t), rm, cyc, wait_n == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
